// File: rtl/logic_unit_pipe_if.sv
// Operand/result bus for logic_unit_pipe. The slave modport is the pipeline side
// and the master modport is the operand source plus the result sink.
interface logic_unit_pipe_if #(
  parameter int WIDTH = 8
);
  // Valid/ready: a transfer happens on a rising edge where valid && ready are both high.
  // The producer holds valid and its payload until the transfer. The consumer may
  // change ready at any time. Neither side waits for the other before raising its signal.
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             acc_sel;
  logic             acc_clr;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;

  modport slave (
    input  in_valid, a, b, op, acc_sel, acc_clr, out_ready,
    output in_ready, out_valid, result, zero
  );

  modport master (
    output in_valid, a, b, op, acc_sel, acc_clr, out_ready,
    input  in_ready, out_valid, result, zero
  );
endinterface

// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined bitwise logic unit with valid/ready on both sides.
// Defining LOGIC_UNIT_ACC_EN adds an accumulator that can stand in for operand B.
module logic_unit_pipe #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  logic_unit_pipe_if.slave    bus
);

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_NOTA = 3'b010;
  localparam logic [2:0] OP_NAND = 3'b011;
  localparam logic [2:0] OP_NOR  = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_XNOR = 3'b110;

  logic             s1_v;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [2:0]       s1_op;
  logic             s1_acc_sel;

  logic             s2_v;
  logic [WIDTH-1:0] s2_result;
  logic             s2_zero;

  logic             accept;
  logic             s2_load;
  logic             drain;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] calc;

  function automatic logic [WIDTH-1:0] logic_op(input logic [2:0] sel,
                                                input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] r;
    case (sel)
      OP_AND:  r = x & y;
      OP_OR:   r = x | y;
      OP_NOTA: r = ~x;
      OP_NAND: r = ~(x & y);
      OP_NOR:  r = ~(x | y);
      OP_XOR:  r = x ^ y;
      OP_XNOR: r = ~(x ^ y);
      default: r = x;
    endcase
    return r;
  endfunction

  // S1 may advance when S2 is empty or draining; only this path is combinational from out_ready.
  assign s2_load      = s1_v && (!s2_v || bus.out_ready);
  assign bus.in_ready = !s1_v || !s2_v || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  assign drain        = s2_v && bus.out_ready;
  assign calc         = logic_op(s1_op, s1_a, b_eff);

  assign bus.out_valid = s2_v;
  assign bus.result    = s2_result;
  assign bus.zero      = s2_zero;

`ifdef LOGIC_UNIT_ACC_EN
  logic [WIDTH-1:0] acc;

  assign b_eff = s1_acc_sel ? acc : s1_b;

  // Clear wins over an update, but a result computed this cycle still saw the old value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (bus.acc_clr) begin
      acc <= '0;
    end else if (s2_load) begin
      acc <= calc;
    end
  end
`else
  logic unused_acc;

  assign b_eff      = s1_b;
  assign unused_acc = ^{s1_acc_sel, bus.acc_clr};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v       <= 1'b0;
      s1_a       <= '0;
      s1_b       <= '0;
      s1_op      <= 3'b000;
      s1_acc_sel <= 1'b0;
    end else begin
      if (accept) begin
        s1_v       <= 1'b1;
        s1_a       <= bus.a;
        s1_b       <= bus.b;
        s1_op      <= bus.op;
        s1_acc_sel <= bus.acc_sel;
      end else if (s2_load) begin
        s1_v <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_v      <= 1'b0;
      s2_result <= '0;
      s2_zero   <= 1'b1;
    end else begin
      if (s2_load) begin
        s2_v      <= 1'b1;
        s2_result <= calc;
        s2_zero   <= (calc == '0);
      end else if (drain) begin
        s2_v <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Bench for logic_unit_pipe: directed vector tables, a scoreboard fed at acceptance,
// and hand-written sequences for latency, backpressure, reset and the accumulator.
module tb_logic_unit_pipe;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   op;
    logic         acc_sel;
    logic [W-1:0] exp;
  } vec_t;

  logic clk;
  logic rst;

  logic_unit_pipe_if #(.WIDTH(W)) bus();

  logic_unit_pipe #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every result leaving the DUT must match the oldest accepted expectation.
  always @(negedge clk) begin
    #2;
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_out: got %0h expected no output", bus.result);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check("sb_result", 32'(bus.result), 32'(e));
        check("sb_zero", 32'(bus.zero), 32'(e == '0));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input vec_t v, output int stalls);
    stalls = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a        = v.a;
    bus.b        = v.b;
    bus.op       = v.op;
    bus.acc_sel  = v.acc_sel;
    #1;
    while (!bus.in_ready && stalls < 50) begin
      @(negedge clk);
      #1;
      stalls++;
    end
    if (!bus.in_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1");
    end else begin
      exp_q.push_back(v.exp);
    end
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    #3;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
  endtask

  // ---------------- test ----------------
  vec_t sweep[9];
  vec_t acc_vec[3];
  vec_t bp_vec[3];

  initial begin
    int stalls;
    int total_stalls;

    sweep[0] = '{8'hF0, 8'hAA, 3'b000, 1'b0, 8'hA0};
    sweep[1] = '{8'hF0, 8'hAA, 3'b001, 1'b0, 8'hFA};
    sweep[2] = '{8'hF0, 8'hAA, 3'b010, 1'b0, 8'h0F};
    sweep[3] = '{8'hF0, 8'hAA, 3'b011, 1'b0, 8'h5F};
    sweep[4] = '{8'hF0, 8'hAA, 3'b100, 1'b0, 8'h05};
    sweep[5] = '{8'hF0, 8'hAA, 3'b101, 1'b0, 8'h5A};
    sweep[6] = '{8'hF0, 8'hAA, 3'b110, 1'b0, 8'hA5};
    sweep[7] = '{8'hF0, 8'hAA, 3'b111, 1'b0, 8'hF0};
    sweep[8] = '{8'h0F, 8'hF0, 3'b000, 1'b0, 8'h00};

    bp_vec[0] = '{8'h11, 8'h22, 3'b001, 1'b0, 8'h33};
    bp_vec[1] = '{8'hFF, 8'h0F, 3'b000, 1'b0, 8'h0F};
    bp_vec[2] = '{8'h55, 8'hFF, 3'b101, 1'b0, 8'hAA};

`ifdef LOGIC_UNIT_ACC_EN
    acc_vec[0] = '{8'h01, 8'h00, 3'b001, 1'b1, 8'h01};
    acc_vec[1] = '{8'h02, 8'h00, 3'b001, 1'b1, 8'h03};
    acc_vec[2] = '{8'h03, 8'h00, 3'b101, 1'b1, 8'h00};
`else
    acc_vec[0] = '{8'h01, 8'h00, 3'b001, 1'b1, 8'h01};
    acc_vec[1] = '{8'h02, 8'h00, 3'b001, 1'b1, 8'h02};
    acc_vec[2] = '{8'h03, 8'h00, 3'b101, 1'b1, 8'h03};
`endif

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.op        = 3'b000;
    bus.acc_sel   = 1'b0;
    bus.acc_clr   = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_result", 32'(bus.result), 32'h00);
    check("rst_zero", 32'(bus.zero), 32'd1);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Single transaction latency: valid appears after the second edge.
    drive('{8'hC3, 8'h0F, 3'b101, 1'b0, 8'hCC}, stalls);
    idle();
    #1;
    check("lat_edge1_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    #1;
    check("lat_edge2_valid", 32'(bus.out_valid), 32'd1);
    check("lat_result", 32'(bus.result), 32'hCC);
    check("lat_zero", 32'(bus.zero), 32'd0);
    wait_drain();

    // Back-to-back sweep: no stalls with out_ready held high.
    total_stalls = 0;
    for (int i = 0; i < 9; i++) begin
      drive(sweep[i], stalls);
      total_stalls += stalls;
    end
    idle();
    check("sweep_stalls", 32'(total_stalls), 32'd0);
    wait_drain();

    // Backpressure: two accepted, third blocked, head held stable.
    bus.out_ready = 1'b0;
    drive(bp_vec[0], stalls);
    drive(bp_vec[1], stalls);
    @(negedge clk);
    bus.a       = bp_vec[2].a;
    bus.b       = bp_vec[2].b;
    bus.op      = bp_vec[2].op;
    bus.acc_sel = bp_vec[2].acc_sel;
    #1;
    check("bp_in_ready", 32'(bus.in_ready), 32'd0);
    check("bp_out_valid", 32'(bus.out_valid), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check("bp_hold_result", 32'(bus.result), 32'h33);
      check("bp_hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
    exp_q.push_back(bp_vec[2].exp);
    @(posedge clk);
    idle();
    wait_drain();

    // Reset with both stages full discards everything in flight.
    bus.out_ready = 1'b0;
    drive(sweep[1], stalls);
    drive(sweep[3], stalls);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    check("full_in_ready", 32'(bus.in_ready), 32'd0);
    rst = 1'b1;
    #1;
    exp_q.delete();
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_result", 32'(bus.result), 32'h00);
    check("midrst_zero", 32'(bus.zero), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      check("postrst_no_valid", 32'(bus.out_valid), 32'd0);
    end

    // Accumulator sequence (plain operand B when the accumulator is absent).
    @(negedge clk);
    bus.acc_clr = 1'b1;
    @(negedge clk);
    bus.acc_clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(acc_vec[i], stalls);
    end
    idle();
    wait_drain();
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/logic_unit_pipe.md
# logic_unit_pipe

Parametrised, pipelined bitwise logic unit; successor to the single-bit combinational gate block. Applies one of eight selectable bitwise operations to two WIDTH-bit operands through a two-stage registered pipeline with valid/ready handshakes on both sides. Sits between an operand source and a result sink in the datapath, and tolerates sink backpressure without dropping or duplicating transactions.

## Interface
- `WIDTH`, default 8, operand/result width in bits (≥1).
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  asynchronous, active-high reset.
- `in_valid`  input  1  operand transaction present.
- `in_ready`  output  1  block accepts transaction this cycle.
- `a`  input  WIDTH  operand A.
- `b`  input  WIDTH  operand B.
- `op`  input  3  operation select (see Operation).
- `acc_sel`  input  1  use accumulator in place of B (accumulate build only).
- `acc_clr`  input  1  clear accumulator (accumulate build only).
- `out_valid`  output  1  result present.
- `out_ready`  input  1  sink accepts result this cycle.
- `result`  output  WIDTH  operation result.
- `zero`  output  1  high when `result` == 0; registered with `result`.

## Operation
- `op` encoding: 000 AND, 001 OR, 010 NOT a (b ignored), 011 NAND, 100 NOR, 101 XOR, 110 XNOR, 111 PASS a.
- All operations bitwise across WIDTH bits; no carries, no width growth.
- Stage 1 (S1): registers `a`, `b`, `op`, `acc_sel`, and valid flag `s1_v` on input accept (`in_valid && in_ready`).
- Stage 2 (S2): computes the operation from S1 registers on S1→S2 transfer, registers `result`, `zero`, and `s2_v`.
- Advance rules: `s2_load = s1_v && (!s2_v || out_ready)`; `in_ready = !s1_v || !s2_v || out_ready`.
- S1 empties on `s2_load` unless refilled the same cycle; S2 empties on `out_valid && out_ready` unless reloaded the same cycle.
- `out_valid = s2_v`. While `out_valid && !out_ready`, `result`/`zero` hold stable.
- Full: both stages valid with `out_ready` low → `in_ready` low; operands are not sampled.
- Simultaneous accept and drain with both stages full and `out_ready` high: all three transfers occur in one cycle; no bubble.
- Strict in-order: results leave in acceptance order, one per transaction.

## Timing
- Reset (async assert, sync-safe release): `s1_v`=0, `s2_v`=0, `result`=0, `zero`=1, accumulator=0; `in_ready`=1 after reset.
- Reset mid-operation: all in-flight transactions discarded, no `out_valid` pulse afterwards for them.
- Latency: input accepted at edge N → `out_valid` high after edge N+1 (two registers), given no backpressure.
- Throughput: one transaction per cycle with `out_ready` held high.
- `in_ready` depends combinationally on `out_ready`; no other combinational input→output paths.

## Configuration
- `LOGIC_UNIT_ACC_EN` defined: WIDTH-bit accumulator register. On `s2_load`, if S1 `acc_sel`=1 the operation uses the accumulator as B; the accumulator is loaded with every computed result. `acc_clr`=1 zeroes the accumulator at the next edge, taking priority over an update in the same cycle; a transaction computed in that same cycle still uses the pre-clear accumulator value.
- Undefined: no accumulator; `acc_sel` and `acc_clr` ports are present but ignored; B is always `b`.

## Test plan
- Reset then single transaction a=8'hC3, b=8'h0F, op=101 → result 8'hCC, zero=0, out_valid two edges after accept.
- Sweep all eight ops with a=8'hF0, b=8'hAA → 8'hA0, FA, 0F, 5F, 05, 5A, A5, F0 in order, back-to-back, one per cycle.
- op=000, a=8'h0F, b=8'hF0 → result 8'h00, zero=1.
- Backpressure: hold out_ready=0 while streaming 3 transactions → in_ready drops after 2 are accepted, result held stable; release → all 3 emerge in order, none lost or duplicated.
- Assert rst with both stages full → out_valid=0, result=0, zero=1 immediately; no stale output after release.
- `LOGIC_UNIT_ACC_EN`: acc_clr, then a=8'h01/op=001/acc_sel=1, a=8'h02/op=001/acc_sel=1, a=8'h03/op=101/acc_sel=1 → results 8'h01, 8'h03, 8'h00; without macro the same stimulus with b=0 → 8'h01, 8'h02, 8'h03.
